nibble_text_streamer: RTL

Converts an unsigned binary value into a stream of ASCII decimal characters, most significant digit first. This is the transmit-side counterpart of our ASCII-digit-to-nibble decoder. A value is accepted on a valid/ready input port and converted to BCD by sequential double-dabble, one shift per cycle. The digits are then emitted one byte per handshake on a valid/ready output port, optionally followed by a terminator character. The block feeds the UART/console text path.

---
 rtl/nibble_text_streamer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/nibble_text_streamer.sv
// nibble_text_streamer: converts an unsigned binary value into ASCII decimal
// characters, most significant digit first, optionally followed by a terminator.
// Conversion is sequential double-dabble (one shift per cycle). Emission is one
// character per valid/ready handshake.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    value input handshake, in_data[W-1:0] unsigned value
//   out_valid/out_ready  character output handshake
//   out_char[7:0]        '0'..'9' or TERM_CHAR
//   out_last             final character of the current value
//   busy                 conversion or emission in progress
module nibble_text_streamer #(
  parameter int unsigned W         = 16,
  parameter int unsigned DIGITS    = 5,
  parameter bit          EMIT_TERM = 1'b1,
  parameter logic [7:0]  TERM_CHAR = 8'h0A
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_char,
  output logic         out_last,
  output logic         busy
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(W + 1);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, CONVERT, EMIT, TERM} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    val_q, val_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            in_ready_d, out_valid_d, out_last_d, busy_d;
  logic [7:0]      out_char_d;
  logic [BW+W-1:0] shifted;
  logic [IW-1:0]   msd;
  logic            handshake;

  // Add 3 to every BCD digit >= 5 ahead of the shift.
  function automatic logic [BW-1:0] dabble(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Index of the most significant nonzero digit; 0 when the value is zero.
  function automatic logic [IW-1:0] msd_of(input logic [BW-1:0] b);
    logic [IW-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] != 4'd0) m = IW'(i);
    end
    return m;
  endfunction

  // ASCII character for digit idx of b.
  function automatic logic [7:0] digit_char(input logic [BW-1:0] b, input logic [IW-1:0] idx);
    logic [BW-1:0] s;
    s = b >> {idx, 2'b00};
    return 8'h30 + {4'h0, s[3:0]};
  endfunction

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      val_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      val_q     <= val_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_char  <= out_char_d;
      out_last  <= out_last_d;
      busy      <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    val_d       = val_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    in_ready_d  = in_ready;
    out_valid_d = out_valid;
    out_char_d  = out_char;
    out_last_d  = out_last;
    busy_d      = busy;
    shifted     = {dabble(bcd_q), val_q} << 1;
    msd         = msd_of(bcd_q);
    handshake   = out_valid && out_ready;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          val_d      = in_data;
          bcd_d      = '0;
          cnt_d      = CW'(W);
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = CONVERT;
        end
      end
      CONVERT: begin
        if (cnt_q != '0) begin
          bcd_d = shifted[W +: BW];
          val_d = shifted[W-1:0];
          cnt_d = cnt_q - CW'(1);
        end else begin
          // All W shifts done: bcd_q is final, start at the leading digit.
          idx_d       = msd;
          out_valid_d = 1'b1;
          out_char_d  = digit_char(bcd_q, msd);
          out_last_d  = !EMIT_TERM && (msd == '0);
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (handshake) begin
          if (idx_q == '0) begin
            if (EMIT_TERM) begin
              out_char_d = TERM_CHAR;
              out_last_d = 1'b1;
              state_d    = TERM;
            end else begin
              out_valid_d = 1'b0;
              out_char_d  = 8'h00;
              out_last_d  = 1'b0;
              busy_d      = 1'b0;
              in_ready_d  = 1'b1;
              state_d     = IDLE;
            end
          end else begin
            idx_d      = idx_q - IW'(1);
            out_char_d = digit_char(bcd_q, idx_q - IW'(1));
            out_last_d = !EMIT_TERM && (idx_q == IW'(1));
          end
        end
      end
      TERM: begin
        if (handshake) begin
          out_valid_d = 1'b0;
          out_char_d  = 8'h00;
          out_last_d  = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
